// File: rtl/dither_ctrl.sv
// Dither sequencer: ramps the LFSR dither gain in and out, applies attenuation,
// and reseeds the generator whenever dither is switched on.
module dither_ctrl #(
    parameter int D_WIDTH   = 19,
    parameter int GAIN_BITS = 4,
    parameter int RAMP_DIV  = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_valid_i,
    input  logic [D_WIDTH-1:0] dith_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic               cfg_en_i,
    input  logic [2:0]         cfg_shift_i,
    output logic               lfsr_reseed_o,
    output logic [D_WIDTH-1:0] dith_o,
    output logic               dith_valid_o,
    output logic               busy_o,
    output logic [1:0]         state_o
);

    localparam int GW = GAIN_BITS + 1;
    localparam int PW = D_WIDTH + GAIN_BITS + 1;
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [GW-1:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GW-1:0] GAIN_LAST = GAIN_FULL - {{GAIN_BITS{1'b0}}, 1'b1};
    localparam logic [GW-1:0] GAIN_ONE  = {{GAIN_BITS{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST  = CW'(RAMP_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] S_OFF       = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_ON        = 2'd2;
    localparam logic [1:0] S_RAMP_DOWN = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [GW-1:0]      gain_q, gain_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         shift_q, shift_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               reseed_q, reseed_d;
    logic               valid_q, valid_d;
    logic [D_WIDTH-1:0] dith_q, dith_d;

    logic               xfer_s;
    logic               step_s;
    logic signed [PW-1:0] dith_ext_s, gain_ext_s, prod_s, scaled_s;

    assign xfer_s = cfg_valid_i && ready_q;
    assign step_s = sample_valid_i && (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_OFF;
            gain_q   <= {GW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            shift_q  <= 3'd0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            reseed_q <= 1'b0;
            valid_q  <= 1'b0;
            dith_q   <= {D_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            reseed_q <= reseed_d;
            valid_q  <= valid_d;
            dith_q   <= dith_d;
        end
    end

    // Next-state: config transfers and strobe-paced gain stepping
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            S_OFF: begin
                if (xfer_s) begin
                    shift_d = cfg_shift_i;
                    if (cfg_en_i) begin
                        state_d = S_RAMP_UP;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = S_OFF;
                    end
                end else begin
                    state_d = S_OFF;
                end
            end
            S_RAMP_UP: begin
                if (step_s) begin
                    cnt_d  = {CW{1'b0}};
                    gain_d = gain_q + GAIN_ONE;
                    if (gain_q == GAIN_LAST) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_RAMP_UP;
                    end
                end else if (sample_valid_i) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_ON: begin
                if (xfer_s) begin
                    shift_d = cfg_shift_i;
                    if (!cfg_en_i) begin
                        state_d = S_RAMP_DOWN;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = S_ON;
                    end
                end else begin
                    state_d = S_ON;
                end
            end
            S_RAMP_DOWN: begin
                if (step_s) begin
                    cnt_d  = {CW{1'b0}};
                    gain_d = gain_q - GAIN_ONE;
                    if (gain_q == GAIN_ONE) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_RAMP_DOWN;
                    end
                end else if (sample_valid_i) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // Scaled dither: signed product with gain, then two floor shifts
    always_comb begin
        dith_ext_s = {{(PW-D_WIDTH){dith_i[D_WIDTH-1]}}, dith_i};
        gain_ext_s = {{(PW-GW){1'b0}}, gain_q};
        prod_s     = dith_ext_s * gain_ext_s;
        scaled_s   = (prod_s >>> GAIN_BITS) >>> shift_q;
    end

    // Output next values, all registered
    always_comb begin
        ready_d  = (state_d == S_OFF) || (state_d == S_ON);
        busy_d   = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN);
        reseed_d = (state_q == S_OFF) && xfer_s && cfg_en_i;
        valid_d  = sample_valid_i;
        if (sample_valid_i) begin
            dith_d = scaled_s[D_WIDTH-1:0];
        end else begin
            dith_d = dith_q;
        end
    end

    assign cfg_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign lfsr_reseed_o = reseed_q;
    assign dith_valid_o  = valid_q;
    assign dith_o        = dith_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_dither_ctrl.sv
// Directed bench for dither_ctrl with RAMP_DIV=4: vector table for the ON-state
// scaling, hand-written sequences for ramps, handshakes and reset.
module tb_dither_ctrl;

    localparam int DW = 19;

    logic          clock = 1'b0;
    logic          reset;
    logic          sample_valid_i;
    logic [DW-1:0] dith_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic          cfg_en_i;
    logic [2:0]    cfg_shift_i;
    logic          lfsr_reseed_o;
    logic [DW-1:0] dith_o;
    logic          dith_valid_o;
    logic          busy_o;
    logic [1:0]    state_o;

    int n_checks = 0;
    int n_pass   = 0;

    dither_ctrl #(.D_WIDTH(DW), .GAIN_BITS(4), .RAMP_DIV(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .sample_valid_i (sample_valid_i),
        .dith_i         (dith_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_en_i       (cfg_en_i),
        .cfg_shift_i    (cfg_shift_i),
        .lfsr_reseed_o  (lfsr_reseed_o),
        .dith_o         (dith_o),
        .dith_valid_o   (dith_valid_o),
        .busy_o         (busy_o),
        .state_o        (state_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] din;
        logic [2:0]    shift;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        sample_valid_i = 1'b1;
        dith_i         = d;
        tick();
        sample_valid_i = 1'b0;
    endtask

    task automatic write_cfg(input logic en, input logic [2:0] sh);
        cfg_valid_i = 1'b1;
        cfg_en_i    = en;
        cfg_shift_i = sh;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    // Drive a full 64-strobe ramp at dith_i=0x100; up=1 gain rises from 0, else falls from 16
    task automatic ramp(input bit up, input string tag);
        int g;
        int extra_reseed = 0;
        for (int k = 1; k <= 64; k++) begin
            g = up ? (k - 1) / 4 : 16 - (k - 1) / 4;
            strobe(19'h00100);
            check({tag, "_dith"}, 32'(dith_o), 32'(g * 16));
            if (lfsr_reseed_o) extra_reseed++;
            if (k < 64) begin
                check({tag, "_busy"}, 32'(busy_o), 32'd1);
            end
        end
        check({tag, "_no_reseed"}, 32'(extra_reseed), 32'd0);
        check({tag, "_end_state"}, 32'(state_o), up ? 32'd2 : 32'd0);
        check({tag, "_end_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_end_ready"}, 32'(cfg_ready_o), 32'd1);
    endtask

    initial begin
        vecs[0] = '{din: 19'h00100, shift: 3'd0, exp: 19'h00100};
        vecs[1] = '{din: 19'h7FF00, shift: 3'd3, exp: 19'h7FFE0};
        vecs[2] = '{din: 19'h7FFFF, shift: 3'd3, exp: 19'h7FFFF};
        vecs[3] = '{din: 19'h3FFFF, shift: 3'd7, exp: 19'h007FF};
        vecs[4] = '{din: 19'h40000, shift: 3'd0, exp: 19'h40000};
        vecs[5] = '{din: 19'h7FFFD, shift: 3'd1, exp: 19'h7FFFE};
        vecs[6] = '{din: 19'h00005, shift: 3'd2, exp: 19'h00001};
        vecs[7] = '{din: 19'h7FFFF, shift: 3'd7, exp: 19'h7FFFF};

        reset = 1'b1;
        sample_valid_i = 1'b0;
        dith_i = '0;
        cfg_valid_i = 1'b0;
        cfg_en_i = 1'b0;
        cfg_shift_i = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ready", 32'(cfg_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_reseed", 32'(lfsr_reseed_o), 32'd0);
        check("rst_dith", 32'(dith_o), 32'd0);
        check("rst_valid", 32'(dith_valid_o), 32'd0);

        // OFF: strobes give zero dither with a one-cycle valid
        for (int i = 0; i < 10; i++) begin
            strobe(19'h00100);
            check("off_valid", 32'(dith_valid_o), 32'd1);
            check("off_dith", 32'(dith_o), 32'd0);
            tick();
            check("off_valid_low", 32'(dith_valid_o), 32'd0);
        end
        check("off_state", 32'(state_o), 32'd0);

        // Enable: reseed pulse, then ramp up
        write_cfg(1'b1, 3'd0);
        check("en_reseed", 32'(lfsr_reseed_o), 32'd1);
        check("en_state", 32'(state_o), 32'd1);
        check("en_ready", 32'(cfg_ready_o), 32'd0);
        check("en_busy", 32'(busy_o), 32'd1);
        tick();
        check("en_reseed_low", 32'(lfsr_reseed_o), 32'd0);
        ramp(1'b1, "up");
        strobe(19'h00100);
        check("on_unity", 32'(dith_o), 32'h100);

        // Table of ON-state scalings at full gain
        foreach (vecs[i]) begin
            write_cfg(1'b1, vecs[i].shift);
            check("vec_state", 32'(state_o), 32'd2);
            strobe(vecs[i].din);
            check("vec_dith", 32'(dith_o), 32'(vecs[i].exp));
        end

        // Disable, hold an enable request through the ramp down
        write_cfg(1'b0, 3'd0);
        check("dis_state", 32'(state_o), 32'd3);
        check("dis_ready", 32'(cfg_ready_o), 32'd0);
        cfg_valid_i = 1'b1;
        cfg_en_i    = 1'b1;
        cfg_shift_i = 3'd0;
        ramp(1'b0, "down");
        strobe(19'h00100);
        check("reen_dith", 32'(dith_o), 32'd0);
        check("reen_state", 32'(state_o), 32'd1);
        check("reen_reseed", 32'(lfsr_reseed_o), 32'd1);
        cfg_valid_i = 1'b0;
        tick();
        check("reen_reseed_low", 32'(lfsr_reseed_o), 32'd0);
        ramp(1'b1, "up2");

        // Config transfer coincident with a strobe: sample uses the old shift
        sample_valid_i = 1'b1;
        dith_i         = 19'h00100;
        cfg_valid_i    = 1'b1;
        cfg_en_i       = 1'b1;
        cfg_shift_i    = 3'd2;
        tick();
        sample_valid_i = 1'b0;
        cfg_valid_i    = 1'b0;
        check("coin_dith", 32'(dith_o), 32'h100);
        check("coin_state", 32'(state_o), 32'd2);
        strobe(19'h00100);
        check("coin_next", 32'(dith_o), 32'h40);

        // Back to OFF, re-enable, stall mid-ramp at gain 7, then reset
        write_cfg(1'b0, 3'd0);
        ramp(1'b0, "down2");
        write_cfg(1'b1, 3'd0);
        check("mid_reseed", 32'(lfsr_reseed_o), 32'd1);
        for (int k = 0; k < 28; k++) strobe(19'h00100);
        check("mid_dith", 32'(dith_o), 32'h60);
        for (int k = 0; k < 20; k++) tick();
        check("stall_busy", 32'(busy_o), 32'd1);
        check("stall_state", 32'(state_o), 32'd1);
        strobe(19'h00100);
        check("stall_gain7", 32'(dith_o), 32'h70);
        reset = 1'b1;
        tick();
        check("mrst_state", 32'(state_o), 32'd0);
        check("mrst_dith", 32'(dith_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_ready", 32'(cfg_ready_o), 32'd1);
        check("mrst_reseed", 32'(lfsr_reseed_o), 32'd0);
        reset = 1'b0;
        tick();
        check("post_reseed", 32'(lfsr_reseed_o), 32'd0);
        check("post_state", 32'(state_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
